uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx instance between NREQ byte producers using round-robin arbitration.
//  Each producer holds a byte on its lane and raises req; the arbiter latches the winning byte.
//  It drives the transmitter's send/data inputs and tracks ready until the frame completes.
//  Sits between the uart_transceiver data_i/send/ready_tx and the system-side producers.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  BURST_LEN 4   max consecutive bytes per grant (used only with UART_ARB_BURST_EN)
// PORTS
//  clk        in   1        system clock, same clock as uart_tx clk
//  rst        in   1        asynchronous, active-low reset (0 = reset)
//  req        in   NREQ     per-requester byte-pending level; lane data stable while high
//  req_data   in   8*NREQ   lane i byte = req_data[8*i+7:8*i]
//  ack        out  NREQ     one-cycle pulse: lane byte latched, requester may change data/req
//  grant_id   out  3        index of lane owning current/last frame
//  busy       out  1        high from latch until frame completion
//  tx_data    out  8        to uart_tx data; registered, stable for whole frame
//  tx_send    out  1        to uart_tx send
//  tx_ready   in   1        from uart_tx ready
// BEHAVIOUR
//  Reset values: ack=0, grant_id=0, busy=0, tx_data=0, tx_send=0, rr pointer=0, state=IDLE.
//  FSM, all transitions on posedge clk:
//   IDLE:   if |req && tx_ready -> pick lane, latch tx_data, pulse ack[lane], set grant_id, busy=1 -> LAUNCH
//   LAUNCH: tx_send=1 held every cycle until tx_ready==0 observed -> WAIT_DONE (tx_send=0 same edge)
//   WAIT_DONE: tx_ready==1 -> frame complete -> IDLE (or LAUNCH under burst, see CONFIGURATION)
//  Latency: req high in IDLE with tx_ready=1 -> ack and tx_data valid next edge; tx_send high 1 cycle later.
//  tx_send stays high across the multi-cycle clk_uart gap until ready drops; never re-asserted within a frame.
//  Round robin: search starts at lane (last_grant+1) mod NREQ; pointer advances only on a grant.
//  Lanes with req=0 are skipped; if no req, stay IDLE, no ack, busy=0.
//  ack is one-hot or zero, never two lanes in one cycle; one ack per byte.
//  req deasserted after ack: ignored; the frame still completes. req deasserted before grant: lane not served.
//  req held high after ack: treated as a new byte; lane re-enters arbitration behind others.
//  tx_ready low in IDLE (transmitter owned elsewhere or still finishing): no grant until it returns high.
//  Async reset mid-frame: all outputs return to reset values immediately; the in-flight byte is abandoned.
//  The uart_tx is reset by the same system.
//  grant_id holds last winner while IDLE; width fixed at 3, upper bits 0 when NREQ<8.
// CONFIGURATION
//  Macro UART_ARB_BURST_EN:
//   defined: in WAIT_DONE with tx_ready==1, if req[grant_id] still high and burst count < BURST_LEN:
//    latch next byte, pulse ack[grant_id], go to LAUNCH without re-arbitration.
//    The burst count resets on every fresh arbitration. After BURST_LEN bytes the lane must re-arbitrate.
//   undefined: every byte re-arbitrates through IDLE; BURST_LEN unused, no burst counter synthesised.
// STRUCTURE
//  Shared include uart_pkg.vh: FSM state localparams (IDLE/LAUNCH/WAIT_DONE), ARB_ID_W=3.
//  Sub-module uart_rr_picker: combinational rotate-priority-encoder.
//   Inputs: req and pointer. Outputs: grant one-hot, grant index and any.
//   Its ports are parameterised by NREQ.
//  Arbiter top holds FSM, pointer, data/ack/burst registers.
// TESTING
//  1 Single lane: req=4'b0100, data 0xA5 -> ack[2] pulse, grant_id=2, tx_data=0xA5.
//    tx_send high until tx_ready falls; busy drops when ready rises.
//  2 Fairness: req=4'b1111 held, distinct bytes -> ack order lanes 1,2,3,0,1 with pointer=0 start.
//    No lane is granted twice before the others.
//  3 Ready gating: tx_ready=0 with req=4'b0001 -> no ack; raise ready -> ack[0] next edge.
//  4 Withdraw: lane 3 drops req after ack -> frame completes, 0x3C on tx, no second ack for lane 3.
//  5 Reset: assert rst low in WAIT_DONE -> ack/busy/tx_send=0 immediately, state IDLE.
//    After release, a new req is served normally.
//  6 Burst (UART_ARB_BURST_EN, BURST_LEN=4): lane 0 req held, lane 1 req high.
//    Result: 4 lane-0 bytes back-to-back, then lane 1 is granted.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared definitions for the UART transmit arbiter:
//               arbiter FSM state encoding, grant index width and the
//               round-robin pointer advance helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

  // Grant index width is fixed so up to 8 lanes fit; unused upper bits stay 0.
  localparam int ARB_ID_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_t;

  // Lane after 'last', wrapping at nreq. 'last' is always a valid lane index.
  function automatic logic [ARB_ID_W-1:0] rr_next(input logic [ARB_ID_W-1:0] last,
                                                 input int nreq);
    if (int'(last) >= nreq - 1) begin
      return '0;
    end
    return last + ARB_ID_W'(1);
  endfunction

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_picker
// Description : Combinational rotate-priority encoder. Searches i_req
//               starting at lane i_start and wrapping, returning the first
//               requesting lane.
// Ports       : i_req   [NREQ-1:0]     request levels
//               i_start [ARB_ID_W-1:0] first lane to examine
//               o_grant [NREQ-1:0]     one-hot winner (zero if none)
//               o_idx   [ARB_ID_W-1:0] winner index (zero if none)
//               o_any                  at least one lane requesting
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]     i_req,
  input  logic [ARB_ID_W-1:0] i_start,
  output logic [NREQ-1:0]     o_grant,
  output logic [ARB_ID_W-1:0] o_idx,
  output logic                o_any
);

  always_comb begin
    int lane;
    lane    = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      lane = (int'(i_start) + k) % NREQ;
      if (!o_any && i_req[lane]) begin
        o_any         = 1'b1;
        o_grant[lane] = 1'b1;
        o_idx         = ARB_ID_W'(lane);
      end
    end
  end

endmodule : uart_rr_picker
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one uart_tx between NREQ byte producers with
//               round-robin arbitration. The winning byte is latched into
//               o_tx_data, o_tx_send is held until the transmitter drops
//               ready, and the frame is complete when ready returns.
// Config      : UART_ARB_BURST_EN - when defined, the granted lane may send
//               up to BURST_LEN consecutive bytes without re-arbitrating.
// Ports       : clk                      system clock (same as uart_tx)
//               rst_n                    asynchronous reset, active low
//               i_req      [NREQ-1:0]    per-lane byte pending
//               i_req_data [8*NREQ-1:0]  lane i byte at [8*i+7:8*i]
//               o_ack      [NREQ-1:0]    one-cycle pulse: lane byte latched
//               o_grant_id [2:0]         lane owning current/last frame
//               o_busy                   latch until frame completion
//               o_tx_data  [7:0]         byte to uart_tx, stable per frame
//               o_tx_send                send strobe to uart_tx
//               i_tx_ready               ready from uart_tx
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     i_req,
  input  logic [8*NREQ-1:0]   i_req_data,
  output logic [NREQ-1:0]     o_ack,
  output logic [ARB_ID_W-1:0] o_grant_id,
  output logic                o_busy,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_send,
  input  logic                i_tx_ready
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [ARB_ID_W-1:0]   r_ptr;        // last granted lane
  logic [NREQ-1:0]       r_ack;
  logic [ARB_ID_W-1:0]   r_grant_id;
  logic                  r_busy;
  logic [7:0]            r_tx_data;
  logic                  r_tx_send;

  logic [ARB_ID_W-1:0]   w_start;
  logic [NREQ-1:0]       w_pick_grant;
  logic [ARB_ID_W-1:0]   w_pick_idx;
  logic                  w_pick_any;

  logic [ARB_ID_W-1:0]   w_sel_idx;
  logic [NREQ-1:0]       w_sel_onehot;
  logic [7:0]            w_sel_data;
  logic                  w_cur_req;

  logic                  w_latch;      // capture a byte this edge
  logic                  w_fresh;      // capture comes from arbitration
  logic                  w_send_nxt;
  logic                  w_busy_nxt;
  logic                  w_burst_ok;

  assign w_start = rr_next(r_ptr, NREQ);

  uart_rr_picker #(
    .NREQ    (NREQ)
  ) u_picker (
    .i_req   (i_req),
    .i_start (w_start),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // In IDLE the picker chooses the lane; otherwise (burst continuation)
  // the current owner keeps the lane.
  assign w_sel_idx = (r_state == ST_IDLE) ? w_pick_idx : r_grant_id;

  always_comb begin
    w_sel_onehot = '0;
    w_sel_data   = '0;
    w_cur_req    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == int'(w_sel_idx)) begin
        w_sel_data = i_req_data[8*i +: 8];
      end
      if (i == int'(r_grant_id)) begin
        w_cur_req = i_req[i];
      end
    end
    if (r_state == ST_IDLE) begin
      w_sel_onehot = w_pick_grant;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        w_sel_onehot[i] = (i == int'(r_grant_id));
      end
    end
  end

`ifdef UART_ARB_BURST_EN
  localparam int BCNT_W = $clog2(BURST_LEN + 1);
  logic [BCNT_W-1:0] r_burst_cnt;   // bytes sent in the current grant

  assign w_burst_ok = w_cur_req && (r_burst_cnt < BCNT_W'(BURST_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else if (w_fresh) begin
      r_burst_cnt <= BCNT_W'(1);
    end else if (w_latch) begin
      r_burst_cnt <= r_burst_cnt + BCNT_W'(1);
    end
  end
`else
  assign w_burst_ok = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_fresh     = 1'b0;
    w_send_nxt  = r_tx_send;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        w_send_nxt = 1'b0;
        if (w_pick_any && i_tx_ready) begin
          w_latch     = 1'b1;
          w_fresh     = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // Only a ready drop seen after send is up counts as acceptance,
        // so send is never re-raised within a frame.
        if (r_tx_send && !i_tx_ready) begin
          w_send_nxt  = 1'b0;
          w_state_nxt = ST_WAIT_DONE;
        end else begin
          w_send_nxt  = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        w_send_nxt = 1'b0;
        if (i_tx_ready) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
          if (w_burst_ok) begin
            w_latch     = 1'b1;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_LAUNCH;
          end
        end
      end
      default: begin
        w_send_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_ack      <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_tx_data  <= '0;
      r_tx_send  <= 1'b0;
    end else begin
      r_ack     <= w_latch ? w_sel_onehot : '0;
      r_busy    <= w_busy_nxt;
      r_tx_send <= w_send_nxt;
      if (w_latch) begin
        r_tx_data  <= w_sel_data;
        r_grant_id <= w_sel_idx;
      end
      if (w_fresh) begin
        r_ptr <= w_pick_idx;
      end
    end
  end

  assign o_ack      = r_ack;
  assign o_grant_id = r_grant_id;
  assign o_busy     = r_busy;
  assign o_tx_data  = r_tx_data;
  assign o_tx_send  = r_tx_send;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with a
//               small behavioural uart_tx ready model. Honours
//               UART_ARB_BURST_EN for the burst scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [2:0]  grant_id;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_send;
  wire         tx_ready;

  logic        model_en;
  logic        man_ready;
  logic        m_ready;
  int          m_phase;
  int          m_cnt;
  logic [7:0]  tx_log[$];
  int          send_rises;
  logic        send_prev;

  int          vectors;
  int          errors;
  int          log_idx;
  logic [3:0]  got;
  int          ack_cnt;

  assign tx_ready = model_en ? m_ready : man_ready;

  uart_tx_arbiter #(
    .NREQ       (4),
    .BURST_LEN  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (req),
    .i_req_data (req_data),
    .o_ack      (ack),
    .o_grant_id (grant_id),
    .o_busy     (busy),
    .o_tx_data  (tx_data),
    .o_tx_send  (tx_send),
    .i_tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart_tx stand-in: accepts send a few cycles late (clk_uart gap),
  // holds ready low for the frame, logs the byte at acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_phase <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (tx_send && m_ready) begin
             m_phase <= 1;
             m_cnt   <= 2;
           end
        1: if (m_cnt == 0) begin
             m_ready <= 1'b0;
             m_phase <= 2;
             m_cnt   <= 5;
             tx_log.push_back(tx_data);
           end else begin
             m_cnt <= m_cnt - 1;
           end
        default: if (m_cnt == 0) begin
             m_ready <= 1'b1;
             m_phase <= 0;
           end else begin
             m_cnt <= m_cnt - 1;
           end
      endcase
    end
  end

  always @(posedge clk) begin
    send_prev <= tx_send;
    if (tx_send && !send_prev) send_rises <= send_rises + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    b = (tx_log.size() > log_idx) ? tx_log[log_idx] : 8'hxx;
    chk(tag, {24'h0, b}, {24'h0, exp});
    log_idx++;
  endtask

  task automatic wait_ack(input int budget, output logic [3:0] a);
    a = 4'h0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (ack != 4'h0) begin
        a = ack;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int n = 0; n < budget && busy !== 1'b0; n++) @(negedge clk);
    chk(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_ready(input logic lvl, input int budget);
    for (int n = 0; n < budget && tx_ready !== lvl; n++) @(negedge clk);
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    log_idx    = 0;
    send_rises = 0;
    send_prev  = 1'b0;
    model_en   = 1'b1;
    man_ready  = 1'b1;
    rst_n      = 1'b0;
    req        = 4'h0;
    req_data   = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ack", {28'h0, ack}, 32'h0);
    chk("rst_grant_id", {29'h0, grant_id}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_tx_send", {31'h0, tx_send}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_noreq_ack", {28'h0, ack}, 32'h0);
    chk("idle_noreq_busy", {31'h0, busy}, 32'h0);

    // 1: single lane 2
    req_data = 32'h00A5_0000;
    req      = 4'b0100;
    @(negedge clk);
    chk("t1_ack", {28'h0, ack}, 32'h4);
    chk("t1_grant_id", {29'h0, grant_id}, 32'h2);
    chk("t1_tx_data", {24'h0, tx_data}, 32'hA5);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    chk("t1_send_early", {31'h0, tx_send}, 32'h0);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_send_up", {31'h0, tx_send}, 32'h1);
    chk("t1_ack_pulse", {28'h0, ack}, 32'h0);
    wait_ready(1'b0, 20);
    chk("t1_send_held", {31'h0, tx_send}, 32'h1);
    @(negedge clk);
    chk("t1_send_down", {31'h0, tx_send}, 32'h0);
    wait_ready(1'b1, 20);
    chk("t1_busy_at_ready", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("t1_busy_done", {31'h0, busy}, 32'h0);
    chk_log("t1_byte", 8'hA5);

    // 2: fairness from pointer 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    req_data = 32'h1312_1110;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] e;
      e = 4'b0001 << ((k + 1) % 4);
      wait_ack(40, got);
      if (k == 4) req = 4'b0000;
      chk("t2_ack", {28'h0, got}, {28'h0, e});
      chk("t2_grant_id", {29'h0, grant_id}, (k + 1) % 4);
    end
    wait_idle("t2_idle", 40);
    chk_log("t2_byte0", 8'h11);
    chk_log("t2_byte1", 8'h12);
    chk_log("t2_byte2", 8'h13);
    chk_log("t2_byte3", 8'h10);
    chk_log("t2_byte4", 8'h11);

    // 3: ready gating
    man_ready = 1'b0;
    model_en  = 1'b0;
    req_data  = 32'h0000_005A;
    req       = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("t3_no_ack", {28'h0, ack}, 32'h0);
    end
    man_ready = 1'b1;
    @(negedge clk);
    chk("t3_ack", {28'h0, ack}, 32'h1);
    model_en = 1'b1;
    req      = 4'b0000;
    wait_idle("t3_idle", 40);
    chk_log("t3_byte", 8'h5A);

    // 4: withdraw after ack
    req_data = 32'h3C00_0000;
    req      = 4'b1000;
    wait_ack(20, got);
    chk("t4_ack", {28'h0, got}, 32'h8);
    req     = 4'b0000;
    ack_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ack != 4'h0) ack_cnt++;
    end
    chk("t4_no_second_ack", ack_cnt, 0);
    chk("t4_busy", {31'h0, busy}, 32'h0);
    chk_log("t4_byte", 8'h3C);

    // 5: async reset in WAIT_DONE
    req_data = 32'h0000_7700;
    req      = 4'b0010;
    wait_ack(20, got);
    chk("t5_ack", {28'h0, got}, 32'h2);
    for (int n = 0; n < 30 && !(tx_ready === 1'b0 && tx_send === 1'b0); n++) @(negedge clk);
    chk("t5_in_wait", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'h0, busy}, 32'h0);
    chk("t5_rst_send", {31'h0, tx_send}, 32'h0);
    chk("t5_rst_ack", {28'h0, ack}, 32'h0);
    chk("t5_rst_grant", {29'h0, grant_id}, 32'h0);
    chk("t5_rst_data", {24'h0, tx_data}, 32'h0);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_log("t5_abandoned", 8'h77);
    @(negedge clk);
    req_data = 32'h0099_0000;
    req      = 4'b0100;
    wait_ack(20, got);
    chk("t5_after_ack", {28'h0, got}, 32'h4);
    chk("t5_after_grant", {29'h0, grant_id}, 32'h2);
    req = 4'b0000;
    wait_idle("t5_idle", 40);
    chk_log("t5_byte", 8'h99);

    // 6: lane 0 held, lane 1 pending; pointer is at lane 2
    req_data = 32'h0000_B1B0;
    req      = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] e;
`ifdef UART_ARB_BURST_EN
      e = (k < 4) ? 4'b0001 : 4'b0010;
`else
      e = (k % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
      wait_ack(40, got);
      if (k == 4) req = 4'b0000;
      chk("t6_ack", {28'h0, got}, {28'h0, e});
    end
    wait_idle("t6_idle", 40);
`ifdef UART_ARB_BURST_EN
    chk_log("t6_byte0", 8'hB0);
    chk_log("t6_byte1", 8'hB0);
    chk_log("t6_byte2", 8'hB0);
    chk_log("t6_byte3", 8'hB0);
    chk_log("t6_byte4", 8'hB1);
`else
    chk_log("t6_byte0", 8'hB0);
    chk_log("t6_byte1", 8'hB1);
    chk_log("t6_byte2", 8'hB0);
    chk_log("t6_byte3", 8'hB1);
    chk_log("t6_byte4", 8'hB0);
`endif
    repeat (3) @(negedge clk);
    chk("send_per_frame", send_rises, tx_log.size());
    chk("frames_total", tx_log.size(), log_idx);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
